// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ readout schedulers: state encoding,
// link word width and default overrun-protection limits.
package daq_pkg;

  // Scheduler state encoding
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_GRANT = 2'd1;
  localparam logic [1:0] STATE_XFER  = 2'd2;
  localparam logic [1:0] STATE_GAP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_GRANT = STATE_GRANT,
    ST_XFER  = STATE_XFER,
    ST_GAP   = STATE_GAP
  } daq_state_e;

  // Link and counter widths
  localparam int LINK_W   = 16;
  localparam int WCNT_W   = 12;
  localparam int TMR_W    = 8;
  localparam int GAPC_W   = 8;
  localparam int CH_IDX_W = 3;

  // Default limits: 32 samples x 100-word frames, idle timeout, link dead time
  localparam int DEF_MAX_WORDS = 3200;
  localparam int DEF_TMO_CYC   = 255;
  localparam int DEF_GAP_CYC   = 4;

endpackage

// File: rtl/daq_readout_arbiter_rr_pick.sv
// Combinational round-robin priority encoder. Scans requests starting
// one above the last-served channel and wraps, so every requester is
// reached within NCH decisions.
module rr_pick
  import daq_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]      req,
  input  logic [CH_IDX_W-1:0] ptr,
  output logic [NCH-1:0]      gnt_oh,
  output logic [CH_IDX_W-1:0] idx,
  output logic                any
);

  // First requester at distance 1..NCH above ptr wins
  always_comb begin
    gnt_oh = '0;
    idx    = '0;
    any    = 1'b0;
    for (int off = 1; off <= NCH; off++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (!any && req[ch] && (((int'(ptr) + off) % NCH) == ch)) begin
          gnt_oh[ch] = 1'b1;
          idx        = CH_IDX_W'(ch);
          any        = 1'b1;
        end else begin
          any = any;
        end
      end
    end
  end

endmodule

// File: rtl/daq_readout_arbiter.sv
// Round-robin scheduler sharing one 16-bit DAQ link between NCH readout
// FIFO channels. Forwards the granted channel's word stream with one
// cycle of latency and protects the link against stalled or runaway
// channels with an idle timeout and a per-grant word limit.
module daq_readout_arbiter
  import daq_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int TMO_CYC   = DEF_TMO_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic                  RCLK,
  input  logic                  RST_B,
  input  logic                  EN,
  input  logic [NCH-1:0]        REQ,
  input  logic [LINK_W*NCH-1:0] DIN,
  input  logic [NCH-1:0]        DV_IN,
  input  logic [NCH-1:0]        LAST_IN,
  output logic [NCH-1:0]        GNT,
  output logic [LINK_W-1:0]     DOUT,
  output logic                  DVALID,
  output logic                  LAST_WRD,
  output logic [CH_IDX_W-1:0]   ACTIVE_CH,
  output logic                  BUSY,
  output logic                  TMO_ERR,
  output logic                  OVR_ERR
);

  daq_state_e            state_r, state_n;
  logic [CH_IDX_W-1:0]   ptr_r, ptr_n;
  logic [NCH-1:0]        gnt_r, gnt_n;
  logic [CH_IDX_W-1:0]   active_ch_r, active_ch_n;
  logic [LINK_W-1:0]     dout_r, dout_n;
  logic                  dvalid_r, dvalid_n;
  logic                  last_r, last_n;
  logic                  busy_r, busy_n;
  logic                  tmo_r, tmo_n;
  logic                  ovr_r, ovr_n;
  logic [WCNT_W-1:0]     word_cnt_r, word_cnt_n;
  logic [TMR_W-1:0]      timer_r, timer_n;
  logic [GAPC_W-1:0]     gap_cnt_r, gap_cnt_n;

  logic [NCH-1:0]        pick_oh_s;
  logic [CH_IDX_W-1:0]   pick_idx_s;
  logic                  pick_any_s;
  logic                  dv_sel_s;
  logic                  last_sel_s;
  logic [LINK_W-1:0]     din_sel_s;
  logic [WCNT_W-1:0]     cnt_inc_s;

  rr_pick #(
    .NCH (NCH)
  ) u_rr_pick (
    .req    (REQ),
    .ptr    (ptr_r),
    .gnt_oh (pick_oh_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // Granted channel's strobes; masking by the grant ignores all other channels
  assign dv_sel_s   = |(DV_IN & gnt_r);
  assign last_sel_s = |(LAST_IN & gnt_r);

  // One-hot AND-OR mux of the granted channel's data word
  always_comb begin
    din_sel_s = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      din_sel_s = din_sel_s | (DIN[LINK_W*ch +: LINK_W] & {LINK_W{gnt_r[ch]}});
    end
  end

  // Next-state and next-output decision for the scheduler
  always_comb begin
    state_n     = state_r;
    ptr_n       = ptr_r;
    gnt_n       = gnt_r;
    active_ch_n = active_ch_r;
    dout_n      = dout_r;
    dvalid_n    = 1'b0;
    last_n      = 1'b0;
    tmo_n       = 1'b0;
    ovr_n       = 1'b0;
    word_cnt_n  = word_cnt_r;
    timer_n     = timer_r;
    gap_cnt_n   = '0;
    cnt_inc_s   = word_cnt_r + 12'd1;

    case (state_r)
      ST_IDLE: begin
        if (EN && pick_any_s) begin
          state_n     = ST_GRANT;
          gnt_n       = pick_oh_s;
          active_ch_n = pick_idx_s;
          ptr_n       = pick_idx_s;
          word_cnt_n  = '0;
          timer_n     = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_GRANT, ST_XFER: begin
        if (dv_sel_s) begin
          dout_n     = din_sel_s;
          dvalid_n   = 1'b1;
          word_cnt_n = cnt_inc_s;
          timer_n    = '0;
          // A genuine end of frame takes precedence over truncation
          if (last_sel_s) begin
            last_n  = 1'b1;
            gnt_n   = '0;
            state_n = ST_GAP;
          end else if (cnt_inc_s == WCNT_W'(MAX_WORDS)) begin
            last_n  = 1'b1;
            ovr_n   = 1'b1;
            gnt_n   = '0;
            state_n = ST_GAP;
          end else begin
            state_n = ST_XFER;
          end
        end else if (timer_r == TMR_W'(TMO_CYC - 1)) begin
          tmo_n   = 1'b1;
          gnt_n   = '0;
          state_n = ST_GAP;
        end else begin
          timer_n = timer_r + 8'd1;
        end
      end

      ST_GAP: begin
        gnt_n      = '0;
        word_cnt_n = '0;
        timer_n    = '0;
        if (gap_cnt_r == GAPC_W'(GAP_CYC - 1)) begin
          state_n = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt_r + 8'd1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State and registered outputs; reset drops the grant immediately
  always_ff @(posedge RCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_r     <= ST_IDLE;
      ptr_r       <= CH_IDX_W'(NCH - 1);
      gnt_r       <= '0;
      active_ch_r <= '0;
      dout_r      <= '0;
      dvalid_r    <= 1'b0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
      tmo_r       <= 1'b0;
      ovr_r       <= 1'b0;
      word_cnt_r  <= '0;
      timer_r     <= '0;
      gap_cnt_r   <= '0;
    end else begin
      state_r     <= state_n;
      ptr_r       <= ptr_n;
      gnt_r       <= gnt_n;
      active_ch_r <= active_ch_n;
      dout_r      <= dout_n;
      dvalid_r    <= dvalid_n;
      last_r      <= last_n;
      busy_r      <= busy_n;
      tmo_r       <= tmo_n;
      ovr_r       <= ovr_n;
      word_cnt_r  <= word_cnt_n;
      timer_r     <= timer_n;
      gap_cnt_r   <= gap_cnt_n;
    end
  end

  assign GNT       = gnt_r;
  assign DOUT      = dout_r;
  assign DVALID    = dvalid_r;
  assign LAST_WRD  = last_r;
  assign ACTIVE_CH = active_ch_r;
  assign BUSY      = busy_r;
  assign TMO_ERR   = tmo_r;
  assign OVR_ERR   = ovr_r;

endmodule

// File: tb/tb_daq_readout_arbiter.sv
// Directed bench for daq_readout_arbiter: rotation, single requester,
// timeout, overrun truncation, asynchronous reset mid-frame and EN gating.
module tb_daq_readout_arbiter;

  localparam int NCH = 4;

  logic              RCLK;
  logic              RST_B;
  logic              EN;
  logic [NCH-1:0]    REQ;
  logic [16*NCH-1:0] DIN;
  logic [NCH-1:0]    DV_IN;
  logic [NCH-1:0]    LAST_IN;
  logic [NCH-1:0]    GNT;
  logic [15:0]       DOUT;
  logic              DVALID;
  logic              LAST_WRD;
  logic [2:0]        ACTIVE_CH;
  logic              BUSY;
  logic              TMO_ERR;
  logic              OVR_ERR;

  int errors = 0;
  int checks = 0;

  int mon_words = 0;
  int mon_lasts = 0;
  int mon_tmo   = 0;
  int mon_ovr   = 0;
  int mon_ovr_with_last = 0;
  logic [15:0] mon_last_dout = 16'h0000;

  daq_readout_arbiter #(.NCH(NCH)) dut (
    .RCLK      (RCLK),
    .RST_B     (RST_B),
    .EN        (EN),
    .REQ       (REQ),
    .DIN       (DIN),
    .DV_IN     (DV_IN),
    .LAST_IN   (LAST_IN),
    .GNT       (GNT),
    .DOUT      (DOUT),
    .DVALID    (DVALID),
    .LAST_WRD  (LAST_WRD),
    .ACTIVE_CH (ACTIVE_CH),
    .BUSY      (BUSY),
    .TMO_ERR   (TMO_ERR),
    .OVR_ERR   (OVR_ERR)
  );

  initial RCLK = 1'b0;
  always #5 RCLK = ~RCLK;

  // Link monitor: tallies forwarded words and event pulses
  always @(negedge RCLK) begin
    if (RST_B) begin
      if (DVALID) mon_words <= mon_words + 1;
      if (LAST_WRD) begin
        mon_lasts     <= mon_lasts + 1;
        mon_last_dout <= DOUT;
      end
      if (TMO_ERR) mon_tmo <= mon_tmo + 1;
      if (OVR_ERR) mon_ovr <= mon_ovr + 1;
      if (OVR_ERR && LAST_WRD) mon_ovr_with_last <= mon_ovr_with_last + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a grant, then check it targets the expected channel
  task automatic wait_gnt(input int ch);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge RCLK);
      if (GNT != '0) begin
        seen = 1;
        break;
      end
    end
    check_val($sformatf("grant seen ch%0d", ch), 32'(seen), 32'd1);
    check_val($sformatf("gnt onehot ch%0d", ch), 32'(GNT), 32'(1 << ch));
    check_val($sformatf("active_ch ch%0d", ch), 32'(ACTIVE_CH), 32'(ch));
  endtask

  // Drive nwords on channel ch; expect the first fwd words forwarded with
  // one cycle latency, and LAST_WRD on the final forwarded word if exp_last
  task automatic stream(input int ch, input int nwords, input logic [15:0] base,
                        input bit drv_last, input int fwd, input bit exp_last);
    int bad = 0;
    for (int n = 0; n < nwords; n++) begin
      DV_IN[ch]           = 1'b1;
      DIN[16*ch +: 16]    = base + 16'(n);
      LAST_IN[ch]         = drv_last && (n == nwords - 1);
      @(negedge RCLK);
      if (n < fwd) begin
        if (DVALID !== 1'b1 || DOUT !== (base + 16'(n))) bad++;
        if (LAST_WRD !== (exp_last && (n == fwd - 1))) bad++;
      end else begin
        if (DVALID !== 1'b0 || LAST_WRD !== 1'b0) bad++;
      end
    end
    DV_IN   = '0;
    LAST_IN = '0;
    check_val($sformatf("stream ch%0d bad words", ch), 32'(bad), 32'd0);
  endtask

  // Count cycles BUSY stays high starting at the current (first GAP) sample
  task automatic gap_len(input string tag);
    int cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge RCLK);
      if (!BUSY) break;
      cnt++;
    end
    check_val(tag, 32'(cnt), 32'd4);
  endtask

  initial begin
    int w0, l0, t0, k;
    int cnt;
    RST_B   = 1'b0;
    EN      = 1'b1;
    REQ     = 4'b1111;
    DIN     = '0;
    DV_IN   = '0;
    LAST_IN = '0;

    // Reset state with all requests pending
    repeat (3) @(negedge RCLK);
    check_val("rst gnt", 32'(GNT), 32'd0);
    check_val("rst dout", 32'(DOUT), 32'd0);
    check_val("rst dvalid", 32'(DVALID), 32'd0);
    check_val("rst last", 32'(LAST_WRD), 32'd0);
    check_val("rst active_ch", 32'(ACTIVE_CH), 32'd0);
    check_val("rst busy", 32'(BUSY), 32'd0);
    check_val("rst errs", 32'({TMO_ERR, OVR_ERR}), 32'd0);

    // Release: channel 0 first, then rotation 1,2,3 with 100-word frames
    RST_B = 1'b1;
    @(negedge RCLK);
    check_val("first gnt", 32'(GNT), 32'd1);
    check_val("first active_ch", 32'(ACTIVE_CH), 32'd0);
    w0 = mon_words;
    l0 = mon_lasts;
    for (int ch = 0; ch < NCH; ch++) begin
      if (ch > 0) wait_gnt(ch);
      if (ch == NCH - 1) REQ = '0;
      stream(ch, 100, 16'(16'h1000 * (ch + 1)), 1'b1, 100, 1'b1);
      gap_len($sformatf("gap after ch%0d", ch));
    end
    repeat (2) @(negedge RCLK);
    check_val("rot words", 32'(mon_words - w0), 32'd400);
    check_val("rot lasts", 32'(mon_lasts - l0), 32'd4);
    check_val("rot idle gnt", 32'(GNT), 32'd0);

    // ch1 never sends data: timeout, then ch3 served
    t0  = mon_tmo;
    w0  = mon_words;
    REQ = 4'b1010;
    wait_gnt(1);
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge RCLK);
      if (TMO_ERR) begin
        k = i;
        break;
      end
    end
    check_val("tmo delay", 32'(k), 32'd255);
    check_val("tmo gnt drop", 32'(GNT), 32'd0);
    check_val("tmo no words", 32'(mon_words - w0), 32'd0);
    gap_len("gap after tmo");
    wait_gnt(3);
    REQ = '0;
    check_val("tmo pulses", 32'(mon_tmo - t0), 32'd1);
    stream(3, 10, 16'h3300, 1'b1, 10, 1'b1);
    gap_len("gap after ch3 short");

    // Single requester ch2 with 16'h7000+n
    REQ = 4'b0100;
    wait_gnt(2);
    REQ = '0;
    stream(2, 100, 16'h7000, 1'b1, 100, 1'b1);
    gap_len("gap after ch2");
    check_val("ch2 last word", 32'(mon_last_dout), 32'h7063);

    // ch0 overrun: 3300 words, truncated at 3200
    w0  = mon_words;
    REQ = 4'b0001;
    wait_gnt(0);
    REQ = '0;
    stream(0, 3300, 16'h0000, 1'b0, 3200, 1'b1);
    check_val("ovr words", 32'(mon_words - w0), 32'd3200);
    check_val("ovr pulses", 32'(mon_ovr), 32'd1);
    check_val("ovr with last", 32'(mon_ovr_with_last), 32'd1);
    check_val("ovr gnt after", 32'(GNT), 32'd0);

    // Asynchronous reset at word 50 of a ch1 frame
    REQ = 4'b0010;
    wait_gnt(1);
    stream(1, 50, 16'h5000, 1'b0, 50, 1'b0);
    RST_B = 1'b0;
    #1;
    check_val("arst gnt", 32'(GNT), 32'd0);
    check_val("arst dvalid", 32'(DVALID), 32'd0);
    check_val("arst last", 32'(LAST_WRD), 32'd0);
    repeat (2) @(negedge RCLK);
    RST_B = 1'b1;
    @(negedge RCLK);
    check_val("regrant ch1", 32'(GNT), 32'b0010);
    REQ = '0;
    stream(1, 100, 16'h5100, 1'b1, 100, 1'b1);
    gap_len("gap after regrant");

    // EN dropped mid-frame: frame completes, no new grant while EN low
    REQ = 4'b0001;
    wait_gnt(0);
    EN  = 1'b0;
    REQ = 4'b1111;
    stream(0, 100, 16'h0a00, 1'b1, 100, 1'b1);
    gap_len("gap en low");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge RCLK);
      if (GNT != '0 || BUSY) cnt++;
    end
    check_val("en low no grant", 32'(cnt), 32'd0);
    EN = 1'b1;
    wait_gnt(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
